// File: rtl/regs_bus_arb.sv
// Two-master arbiter/sequencer for the PWM register-file bus.
// Optional REGS_ADDR_CHECK_EN: bad addresses complete through an ERR beat.
module regs_bus_arb #(
    parameter int MAX_LOCK = 2,
    parameter int AW       = 6,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic [1:0]    grant,
    output logic          read,
    output logic          write,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_write,
    input  logic [DW-1:0] data_read
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD1,
        S_RD2,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;
    logic          r_last;
    logic          r_lock_act;
    logic [3:0]    r_lock_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_any;
    logic          w_lock_hold;
    logic          w_pick;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_bad;
    logic          w_ack;
    logic          w_lock_sel;
    logic          w_lock_go;

    assign w_any       = req0 | req1;
    assign w_lock_hold = r_lock_act & (r_last ? req1 : req0);

    always_comb begin
        w_pick = 1'b0;
        if (w_lock_hold)
            w_pick = r_last;
        else if (req0 && req1)
            w_pick = ~r_last;
        else
            w_pick = req1;
    end

    assign w_sel_we    = w_pick ? we1    : we0;
    assign w_sel_addr  = w_pick ? addr1  : addr0;
    assign w_sel_wdata = w_pick ? wdata1 : wdata0;

`ifdef REGS_ADDR_CHECK_EN
    always_comb begin
        w_bad = 1'b1;
        case (int'(w_sel_addr))
            0, 2, 3, 5, 7, 8, 10, 11, 12, 13: w_bad = 1'b0;
            default: w_bad = 1'b1;
        endcase
        // 0x08 is the read-only counter value
        if (w_sel_we && int'(w_sel_addr) == 8)
            w_bad = 1'b1;
    end
    assign err0 = (r_state == S_ERR) & ~r_owner;
    assign err1 = (r_state == S_ERR) &  r_owner;
`else
    assign w_bad = 1'b0;
    assign err0  = 1'b0;
    assign err1  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        write  = 1'b0;
        read   = 1'b0;
        w_ack  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_bad)
                        w_next = S_ERR;
                    else if (w_sel_we)
                        w_next = S_WR;
                    else
                        w_next = S_RD1;
                end
            end
            S_WR: begin
                write  = 1'b1;
                w_ack  = 1'b1;
                w_next = S_IDLE;
            end
            S_RD1: begin
                read   = 1'b1;
                w_next = S_RD2;
            end
            S_RD2: begin
                read   = 1'b1;
                w_ack  = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                w_ack  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_lock_sel = r_owner ? lock1 : lock0;
    assign w_lock_go  = w_lock_sel &&
                        (({1'b0, r_lock_cnt} + 5'd1) < 5'(MAX_LOCK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_lock_act <= 1'b0;
            r_lock_cnt <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                // owner released its lock: fall back to round-robin
                if (r_lock_act && !w_lock_hold)
                    r_lock_act <= 1'b0;
                if (w_any) begin
                    r_owner <= w_pick;
                    r_addr  <= w_sel_addr;
                    r_wdata <= w_sel_wdata;
                end
            end
            if (w_ack) begin
                r_last <= r_owner;
                if (w_lock_go) begin
                    r_lock_act <= 1'b1;
                    r_lock_cnt <= r_lock_cnt + 4'd1;
                end else begin
                    r_lock_act <= 1'b0;
                    r_lock_cnt <= 4'd0;
                end
            end
            if (r_state == S_RD2) begin
                if (r_owner)
                    r_rdata1 <= data_read;
                else
                    r_rdata0 <= data_read;
            end
        end
    end

    assign ack0       = w_ack & ~r_owner;
    assign ack1       = w_ack &  r_owner;
    assign grant      = (r_state == S_IDLE) ? 2'b00 :
                        (r_owner ? 2'b10 : 2'b01);
    assign addr       = r_addr;
    assign data_write = r_wdata;
    assign rdata0     = (r_state == S_RD2 && !r_owner) ? data_read : r_rdata0;
    assign rdata1     = (r_state == S_RD2 &&  r_owner) ? data_read : r_rdata1;

endmodule

// File: tb/tb_regs_bus_arb.sv
// Bench for regs_bus_arb: transaction model checked every cycle plus
// directed literal checks. Honours REGS_ADDR_CHECK_EN like the design.
module tb_regs_bus_arb;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic          lock0 = 0, lock1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, err0, err1, read, write;
    logic [DW-1:0] rdata0, rdata1, data_write, data_read;
    logic [1:0]    grant;
    logic [AW-1:0] addr;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regs_bus_arb #(.MAX_LOCK(ML), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .grant(grant),
        .read(read), .write(write), .addr(addr),
        .data_write(data_write), .data_read(data_read)
    );

    // register file stand-in: read buffer loads at the end of each read cycle
    logic [DW-1:0] env_mem [64];
    logic [DW-1:0] rbuf;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= '0;
            rbuf <= '0;
        end else begin
            if (write) env_mem[addr] <= data_write;
            if (read)  rbuf <= env_mem[addr];
        end
    end
    assign data_read = rbuf;

    // transaction-level model
    bit            m_busy, m_owner, m_last, m_lact;
    int            m_left, m_kind, m_lcnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rd [2];
    logic [DW-1:0] exp_mem [64];

    function automatic bit addr_ok(logic [AW-1:0] a, logic w);
`ifdef REGS_ADDR_CHECK_EN
        if (w && a == 6'h08) return 1'b0;
        return a inside {6'h00, 6'h02, 6'h03, 6'h05, 6'h07,
                         6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D};
`else
        return (a == a) || w;
`endif
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_lact = 0;
        m_left = 0; m_kind = 0; m_lcnt = 0;
        m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    endtask

    // inputs change at negedge+2, so at a negedge they still hold what
    // the preceding posedge sampled
    task automatic model_step();
        bit r [2];
        bit win, w, lk;
        r[0] = req0; r[1] = req1;
        if (m_busy) begin
            if (m_left == 1) begin
                if (m_kind == 0) exp_mem[m_addr] = m_wdata;
                if (m_kind == 1) m_rd[m_owner] = exp_mem[m_addr];
                m_last = m_owner;
                lk = m_owner ? lock1 : lock0;
                if (lk && (m_lcnt + 1) < ML) begin
                    m_lact = 1; m_lcnt = m_lcnt + 1;
                end else begin
                    m_lact = 0; m_lcnt = 0;
                end
                m_busy = 0;
            end else begin
                m_left = m_left - 1;
            end
        end else begin
            if (m_lact && !r[m_last]) m_lact = 0;
            if (r[0] || r[1]) begin
                if (m_lact) win = m_last;
                else if (r[0] && r[1]) win = !m_last;
                else win = r[1];
                m_owner = win;
                m_addr  = win ? addr1 : addr0;
                m_wdata = win ? wdata1 : wdata0;
                w       = win ? we1 : we0;
                if (!addr_ok(m_addr, w)) begin m_kind = 2; m_left = 1; end
                else if (w) begin m_kind = 0; m_left = 1; end
                else begin m_kind = 1; m_left = 2; end
                m_busy = 1;
            end
        end
    endtask

    initial begin
        logic [1:0] eg;
        logic e_wr, e_rd, e_lst, e_a0, e_a1, e_e0, e_e1, ok;
        logic [DW-1:0] e_r0, e_r1;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            else model_step();
            eg    = m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            e_wr  = m_busy && m_kind == 0;
            e_rd  = m_busy && m_kind == 1;
            e_lst = m_busy && m_left == 1;
            e_a0  = e_lst && !m_owner;
            e_a1  = e_lst && m_owner;
            e_e0  = e_a0 && m_kind == 2;
            e_e1  = e_a1 && m_kind == 2;
            e_r0  = (e_a0 && m_kind == 1) ? exp_mem[m_addr] : m_rd[0];
            e_r1  = (e_a1 && m_kind == 1) ? exp_mem[m_addr] : m_rd[1];
            ok = (grant == eg) && (write == e_wr) && (read == e_rd) &&
                 (ack0 == e_a0) && (ack1 == e_a1) &&
                 (err0 == e_e0) && (err1 == e_e1) &&
                 (rdata0 == e_r0) && (rdata1 == e_r1);
            if ((e_wr || e_rd) && addr != m_addr) ok = 0;
            if (e_wr && data_write != m_wdata) ok = 0;
            n_checks++;
            if (!ok) begin
                n_err++;
                $display("FAIL model t=%0t got g=%b w=%b r=%b ack=%b%b err=%b%b rd=%h/%h a=%h d=%h want g=%b w=%b r=%b ack=%b%b err=%b%b rd=%h/%h a=%h d=%h",
                         $time, grant, write, read, ack0, ack1, err0, err1,
                         rdata0, rdata1, addr, data_write,
                         eg, e_wr, e_rd, e_a0, e_a1, e_e0, e_e1,
                         e_r0, e_r1, m_addr, m_wdata);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    int exp3 [8] = '{1, 0, 2, 0, 1, 0, 2, 0};
    int exp4 [7] = '{1, 0, 1, 0, 2, 0, 1};

    initial begin
        nxt();
        chk("rst_grant", grant, 0);
        chk("rst_bus", {read, write, ack0, ack1, err0, err1}, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        #1 rst_n = 1;
        nxt();

        // single write
        #1 req0 = 1; we0 = 1; addr0 = 6'h0A; wdata0 = 8'h05;
        nxt();
        chk("wr_pulse", {write, read, ack0, ack1}, 4'b1010);
        chk("wr_grant", grant, 1);
        chk("wr_addr", addr, 6'h0A);
        chk("wr_data", data_write, 8'h05);
        #1 req0 = 0;
        nxt();
        chk("wr_done", {grant, write, ack0}, 0);

        // read back on master 1
        #1 req1 = 1; we1 = 0; addr1 = 6'h0A;
        nxt();
        chk("rd1", {grant, read, write, ack1}, 5'b10100);
        nxt();
        chk("rd2", {read, ack1}, 2'b11);
        chk("rd2_data", rdata1, 8'h05);
        #1 req1 = 0;
        nxt();
        chk("rd_hold", {read, ack1, rdata1}, {2'b00, 8'h05});

        // contention, no lock
        #1 req0 = 1; we0 = 1; addr0 = 6'h02; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 6'h03; wdata1 = 8'h22;
        for (int i = 0; i < 8; i++) begin
            nxt();
            chk($sformatf("rr_grant%0d", i), grant, exp3[i]);
            chk($sformatf("rr_ack%0d", i), {ack0, ack1},
                {exp3[i] == 1, exp3[i] == 2});
        end
        #1 req0 = 0; req1 = 0;
        nxt();

        // locked two-beat write from master 0 while master 1 waits
        #1 lock0 = 1; req0 = 1; we0 = 1; addr0 = 6'h00; wdata0 = 8'hAA;
        req1 = 1; we1 = 1; addr1 = 6'h05; wdata1 = 8'h33;
        for (int i = 0; i < 7; i++) begin
            nxt();
            chk($sformatf("lk_grant%0d", i), grant, exp4[i]);
            chk($sformatf("lk_ack%0d", i), {ack0, ack1},
                {exp4[i] == 1, exp4[i] == 2});
            #1;
            if (i == 0) begin addr0 = 6'h01; wdata0 = 8'hBB; end
            if (i == 2) begin addr0 = 6'h03; wdata0 = 8'hCC; end
            if (i == 4) req1 = 0;
            if (i == 6) begin req0 = 0; lock0 = 0; end
        end
        nxt();

        // reset during RD1
        #1 req0 = 1; we0 = 0; addr0 = 6'h02;
        nxt();
        chk("rs_rd1", {grant, read}, 3'b011);
        rst_n = 0;
        #1;
        chk("rs_now", {grant, read, write, ack0, ack1}, 0);
        req0 = 0;
        nxt();
        chk("rs_hold", {grant, read, ack0}, 0);
        #1 rst_n = 1;
        req0 = 1; we0 = 1; addr0 = 6'h07; wdata0 = 8'h44;
        req1 = 1; we1 = 1; addr1 = 6'h0B; wdata1 = 8'h55;
        nxt();
        chk("rs_tie", {grant, ack0}, 3'b011);
        nxt();
        nxt();
        chk("rs_next", {grant, ack1}, 3'b101);
        #1 req0 = 0; req1 = 0;
        nxt();

        // req dropped early: beat still completes
        #1 req1 = 1; we1 = 0; addr1 = 6'h07;
        nxt();
        chk("ed_rd1", {grant, read}, 3'b101);
        #1 req1 = 0;
        nxt();
        chk("ed_ack", {ack1, rdata1}, {1'b1, 8'h44});
        nxt();
        chk("ed_idle", {grant, ack1, rdata1}, {3'b000, 8'h44});

        // address check stimulus
        #1 req0 = 1; we0 = 1; addr0 = 6'h08; wdata0 = 8'h77;
        nxt();
`ifdef REGS_ADDR_CHECK_EN
        chk("ac_wr", {grant, ack0, err0, write, read}, 6'b011100);
`else
        chk("ac_wr", {grant, ack0, err0, write, read}, 6'b011010);
`endif
        #1 req0 = 0;
        nxt();
        #1 req1 = 1; we1 = 0; addr1 = 6'h3F;
        nxt();
`ifdef REGS_ADDR_CHECK_EN
        chk("ac_rd", {grant, ack1, err1, read, write}, 6'b101100);
        chk("ac_rdata", rdata1, 8'h44);
        #1 req1 = 0;
        nxt();
`else
        chk("ac_rd1", {grant, ack1, err1, read}, 5'b10001);
        nxt();
        chk("ac_rd2", {ack1, err1, read, rdata1}, {3'b101, 8'h00});
        #1 req1 = 0;
        nxt();
`endif
        nxt();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/regs_bus_arb.md
Name: regs_bus_arb

Overview:
- Two-master arbiter and sequencer for the PWM register-file bus (read/write/addr/data_write/data_read).
- Shares the register file between the SPI decoder (master 0) and an on-chip auto-update engine (master 1).
- Generates the two-cycle read sequence that the register file requires, and the one-cycle write.
- Provides locked multi-beat ownership so the byte halves of 16-bit registers (period, compare1, compare2) are updated atomically.

Parameters:
- MAX_LOCK, 2: maximum consecutive beats one master may hold under lock. Range 1..15; 1 means lock has no effect.
- AW, 6: address width.
- DW, 8: data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  master requests a beat; held stable until that master's ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  target register address
- wdata0 / wdata1  in  DW  write data
- lock0 / lock1  in  1  keep ownership for the master's next beat
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read data; valid in the ack cycle, held until the next ack to that master
- err0 / err1  out  1  error flag; see Optional Feature
- grant  out  2  one-hot current owner; 00 when idle
- read  out  1  to register file
- write  out  1  to register file
- addr  out  AW  to register file
- data_write  out  DW  to register file
- data_read  in  DW  from register file

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, lock_active=0, lock_cnt=0, last_owner=1 (so master 0 wins the first tie).
- FSM states: IDLE, WR, RD1, RD2.
- IDLE arbitration:
  - If lock_active and the owner's req=1: grant the owner; the other master is ignored.
  - If lock_active and the owner's req=0: clear lock_active, then arbitrate normally in the same cycle.
  - Normal arbitration is round-robin: with both requesting, grant the master that is not last_owner; with one requesting, grant it.
  - On grant, register addr/we/wdata of the winner, set grant, and go to WR (we=1) or RD1 (we=0).
- WR: write=1 and addr/data_write driven for exactly 1 cycle. ack_owner=1 in the same cycle. Next state IDLE.
- RD1: read=1; the register file loads its read buffer at the end of this cycle.
- RD2: read=1 again. Capture data_read into rdata_owner and pulse ack_owner. Next state IDLE.
- read and write are never high together. Both are 0 in IDLE.
- Lock update in the ack cycle:
  - If lock_owner=1 and lock_cnt+1 < MAX_LOCK: lock_active=1 and lock_cnt increments.
  - Otherwise: lock_active=0 and lock_cnt=0.
- last_owner is updated to the owner in every ack cycle.
- grant stays asserted from the grant cycle through the ack cycle, and is 00 in IDLE.
- Latency from req seen in IDLE:
  - Write: ack 1 cycle later; throughput 1 beat per 2 cycles.
  - Read: ack 2 cycles later; throughput 1 beat per 3 cycles.
- A master's req must stay high until its ack. Dropping req early is a protocol violation, but the bus op still completes and the ack is still pulsed.
- The non-granted master's ack stays 0, and its rdata is unchanged.
- Reset asserted mid-transaction: the FSM and all outputs return to reset values at once. No partial write pulse extends past reset.

Optional Feature:
- Macro REGS_ADDR_CHECK_EN.
- Defined:
  - In IDLE, a granted address that is not one of 0x00, 0x02, 0x03, 0x05, 0x07, 0x08, 0x0A, 0x0B, 0x0C, 0x0D skips WR/RD.
  - Instead it goes to a one-cycle ERR state that pulses ack_owner and err_owner together.
  - No read/write is asserted, rdata is unchanged, and the lock rules still apply.
  - A write to 0x08 (read-only counter value) also errors.
- Not defined: all addresses pass through to the register file, and err0/err1 are tied to 0.

Test Plan:
- Single write: req0=1, we0=1, addr0=0x0A, wdata0=0x05 → write=1 for one cycle with addr=0x0A, data_write=0x05; ack0 in that same cycle, 1 cycle after req seen; grant=01 for exactly that one cycle.
- Read: prescale holds 0x05; req1 read at addr 0x0A → read=1 for 2 cycles; ack1 on the 2nd cycle with rdata1=0x05.
- Contention: req0 and req1 both write continuously with no lock → grants alternate 01, 10, 01, 10; each ack spaced 2 cycles apart.
- Atomic 16-bit write with MAX_LOCK=2: master 0 locked writes to 0x00 then 0x01 while req1 is held high → master 1 is not granted until both master-0 acks complete. With MAX_LOCK=2, a third locked beat from master 0 loses to master 1.
- Reset mid-transaction: assert rst_n=0 during RD1 → read=0, grant=00, no ack; after release, the first tie goes to master 0.
- With REGS_ADDR_CHECK_EN defined: write to 0x08 and read of 0x3F → each gets an ack+err pulse 1 cycle after grant, with read and write never asserted. Without the macro: the same stimulus reaches the bus and err stays 0.
